// File: rtl/ecc_err_inject.sv
// rtl/ecc_err_inject.sv - LFSR-driven bit-flip injector between an ECC encoder and decoder
//
// Sits in a codeword stream and corrupts 0, 1 or 2 bits of each accepted
// codeword. Flip positions come from a 16-bit Galois LFSR that advances once
// per accepted word, so a given seed always reproduces the same error pattern.
//
// Parameters
//   K       data bits per codeword; M check bits and N = M+K+1 total bits derived
//   P0_LSB  overall-parity bit placement (0: bit N-1, 1: bit 0); flip indices are
//           always physical bit positions, so this only qualifies the report
//   SEED    LFSR reset value (nonzero)
//
// Ports
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   mode_i                      0 none, 1 single, 2 double, 3 random 0/1/2 flips
//   seed_ld_i, seed_i           synchronous LFSR load
//   clr_cnt_i                   synchronous clear of the injection counters
//   cw_valid_i/cw_ready_o/cw_i  upstream codeword handshake
//   cw_valid_o/cw_ready_i/cw_o  downstream corrupted codeword handshake
//   nflips_o, flip1_o, flip2_o  flips applied to cw_o and their bit indices
//   sb_cnt_o, db_cnt_o          saturating single / double injection counts

module ecc_err_inject #(
    parameter int          K      = 8,
    parameter int          P0_LSB = 0,
    parameter logic [15:0] SEED   = 16'hACE1,
    // Smallest m with 2**m >= m+K+1, i.e. 2**m - m - 1 >= K.
    localparam int         M      = (K <= 1)  ? 2 :
                                    (K <= 4)  ? 3 :
                                    (K <= 11) ? 4 :
                                    (K <= 26) ? 5 :
                                    (K <= 57) ? 6 :
                                    (K <= 120) ? 7 : 8,
    localparam int         N      = M + K + 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [1:0]   mode_i,
    input  logic         seed_ld_i,
    input  logic [15:0]  seed_i,
    input  logic         clr_cnt_i,
    input  logic         cw_valid_i,
    output logic         cw_ready_o,
    input  logic [N-1:0] cw_i,
    output logic         cw_valid_o,
    input  logic         cw_ready_i,
    output logic [N-1:0] cw_o,
    output logic [1:0]   nflips_o,
    output logic [7:0]   flip1_o,
    output logic [7:0]   flip2_o,
    output logic [15:0]  sb_cnt_o,
    output logic [15:0]  db_cnt_o
);

    // Indices must fit the 8-bit report fields, and P0_LSB is a flag.
    if (N > 255 || (P0_LSB != 0 && P0_LSB != 1)) begin : g_bad_param
        $error("ecc_err_inject: unsupported K or P0_LSB");
    end

    logic [15:0] lfsr;
    logic        accept;
    logic [8:0]  pos1;
    logic [8:0]  off;
    logic [8:0]  pos2_sum;
    logic [8:0]  pos2;
    logic [1:0]  nflips_nxt;
    logic [N-1:0] mask1;
    logic [N-1:0] mask2;
    logic [N-1:0] cw_nxt;
    logic [15:0] lfsr_step;
    logic [15:0] seed_val;

    // Single output register stage: a new word may enter whenever the stage
    // is empty or is being drained in the same cycle.
    assign cw_ready_o = !cw_valid_o || cw_ready_i;
    assign accept     = cw_valid_i && cw_ready_o;

    // Second position is drawn from the N-1 positions other than pos1, so
    // the two flips never cancel each other.
    assign pos1     = 9'(32'(lfsr[7:0]) % N);
    assign off      = 9'(32'(lfsr[15:8]) % (N - 1));
    assign pos2_sum = pos1 + 9'd1 + off;
    assign pos2     = (pos2_sum >= 9'(N)) ? pos2_sum - 9'(N) : pos2_sum;

    always_comb begin
        nflips_nxt = 2'd0;
        case (mode_i)
            2'd0: nflips_nxt = 2'd0;
            2'd1: nflips_nxt = 2'd1;
            2'd2: nflips_nxt = 2'd2;
            default: begin
                // Random mode: 11 maps to a single flip, biasing toward the
                // correctable case.
                case (lfsr[15:14])
                    2'b00:   nflips_nxt = 2'd0;
                    2'b10:   nflips_nxt = 2'd2;
                    default: nflips_nxt = 2'd1;
                endcase
            end
        endcase
    end

    assign mask1  = {{(N-1){1'b0}}, 1'b1} << pos1;
    assign mask2  = {{(N-1){1'b0}}, 1'b1} << pos2;

    always_comb begin
        cw_nxt = cw_i;
        if (nflips_nxt != 2'd0) begin
            cw_nxt = cw_nxt ^ mask1;
        end
        if (nflips_nxt == 2'd2) begin
            cw_nxt = cw_nxt ^ mask2;
        end
    end

    assign lfsr_step = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    // An all-zero Galois LFSR would lock up.
    assign seed_val  = (seed_i == 16'h0000) ? 16'h0001 : seed_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr <= SEED;
        end else if (seed_ld_i) begin
            lfsr <= seed_val;
        end else if (accept) begin
            lfsr <= lfsr_step;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cw_valid_o <= 1'b0;
            cw_o       <= '0;
            nflips_o   <= 2'd0;
            flip1_o    <= 8'd0;
            flip2_o    <= 8'd0;
        end else if (accept) begin
            cw_valid_o <= 1'b1;
            cw_o       <= cw_nxt;
            nflips_o   <= nflips_nxt;
            flip1_o    <= (nflips_nxt != 2'd0) ? 8'(pos1) : 8'd0;
            flip2_o    <= (nflips_nxt == 2'd2) ? 8'(pos2) : 8'd0;
        end else if (cw_valid_o && cw_ready_i) begin
            cw_valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sb_cnt_o <= 16'd0;
            db_cnt_o <= 16'd0;
        end else if (clr_cnt_i) begin
            sb_cnt_o <= 16'd0;
            db_cnt_o <= 16'd0;
        end else if (accept) begin
            if (nflips_nxt == 2'd1 && sb_cnt_o != 16'hFFFF) begin
                sb_cnt_o <= sb_cnt_o + 16'd1;
            end
            if (nflips_nxt == 2'd2 && db_cnt_o != 16'hFFFF) begin
                db_cnt_o <= db_cnt_o + 16'd1;
            end
        end
    end

endmodule
